// File: rtl/vend_change_controller_if.sv
// Handshake and status bundle between vend_change_controller and its neighbours.
// Defining VEND_STATS_EN adds the sales_cnt / change_cents statistics outputs.
interface vend_change_controller_if #(
  parameter int CREDIT_W = 8,
  parameter int INV_W    = 6
);
  logic                vend_req;
  logic [2:0]          vend_item;
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] price;
  logic                busy;
  logic                item_valid;
  logic [2:0]          item_sel;
  logic                item_ready;
  logic                coin_valid;
  logic [1:0]          coin_type;
  logic                coin_ready;
  logic                done;
  logic [1:0]          status;
  logic                refill_valid;
  logic [1:0]          refill_type;
  logic [INV_W-1:0]    inv_n;
  logic [INV_W-1:0]    inv_d;
  logic [INV_W-1:0]    inv_q;
`ifdef VEND_STATS_EN
  logic [15:0]         sales_cnt;
  logic [15:0]         change_cents;

  modport master (
    output vend_req, vend_item, credit, price, item_ready, coin_ready,
           refill_valid, refill_type,
    input  busy, item_valid, item_sel, coin_valid, coin_type, done, status,
           inv_n, inv_d, inv_q, sales_cnt, change_cents
  );

  modport slave (
    input  vend_req, vend_item, credit, price, item_ready, coin_ready,
           refill_valid, refill_type,
    output busy, item_valid, item_sel, coin_valid, coin_type, done, status,
           inv_n, inv_d, inv_q, sales_cnt, change_cents
  );
`else
  modport master (
    output vend_req, vend_item, credit, price, item_ready, coin_ready,
           refill_valid, refill_type,
    input  busy, item_valid, item_sel, coin_valid, coin_type, done, status,
           inv_n, inv_d, inv_q
  );

  modport slave (
    input  vend_req, vend_item, credit, price, item_ready, coin_ready,
           refill_valid, refill_type,
    output busy, item_valid, item_sel, coin_valid, coin_type, done, status,
           inv_n, inv_d, inv_q
  );
`endif
endinterface

// File: rtl/vend_change_controller.sv
// Vend transaction sequencer: credit check, greedy change planning, item release, coin issue.
// Optional VEND_STATS_EN adds sales and dispensed-change counters.
module vend_change_controller #(
  parameter int CREDIT_W = 8,
  parameter int INV_W    = 6,
  parameter int INIT_N   = 20,
  parameter int INIT_D   = 20,
  parameter int INIT_Q   = 20
) (
  input logic                  clk,
  input logic                  rst_n,
  vend_change_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, PLAN, ITEM, CHANGE, FINISH} state_t;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_CREDIT = 2'b01;
  localparam logic [1:0] ST_CHANGE = 2'b10;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, price_reg, rem_reg;
  logic [2:0]          item_reg;
  logic [1:0]          status_reg;

  // Index 0/1/2 = nickel/dime/quarter, matching the coin_type encoding.
  logic [2:0][INV_W-1:0] inv_vec;
  logic [2:0]            fit_vec;
  logic [2:0]            plan_nz;

  logic       pick_any, plan_take, plan_fail, plan_any, coin_hs;
  logic [1:0] pick_idx, coin_sel;
  logic       busy, item_valid, coin_valid, done;
  logic [1:0] coin_type;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    logic [CREDIT_W-1:0] v;
    case (t)
      2'd0:    v = CREDIT_W'(5);
      2'd1:    v = CREDIT_W'(10);
      default: v = CREDIT_W'(25);
    endcase
    return v;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_coin
      localparam int         INIT_V = (gi == 0) ? INIT_N : (gi == 1) ? INIT_D : INIT_Q;
      localparam logic [1:0] TYPE   = 2'(gi);

      logic [INV_W-1:0] inv_reg, shadow_reg, plan_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          inv_reg    <= INV_W'(INIT_V);
          shadow_reg <= '0;
          plan_reg   <= '0;
        end else begin
          // Refill only happens in IDLE and coin handshakes only in CHANGE.
          if (state_reg == IDLE && bus.refill_valid && bus.refill_type == TYPE) begin
            if (inv_reg != '1)
              inv_reg <= inv_reg + INV_W'(1);
          end else if (coin_hs && coin_sel == TYPE) begin
            inv_reg <= inv_reg - INV_W'(1);
          end

          if (state_reg == CHECK)
            shadow_reg <= inv_reg;
          else if (plan_take && pick_idx == TYPE)
            shadow_reg <= shadow_reg - INV_W'(1);

          if (plan_fail)
            plan_reg <= '0;
          else if (plan_take && pick_idx == TYPE)
            plan_reg <= plan_reg + INV_W'(1);
          else if (coin_hs && coin_sel == TYPE)
            plan_reg <= plan_reg - INV_W'(1);
        end
      end

      assign fit_vec[gi] = (shadow_reg != '0) && (rem_reg >= coin_value(TYPE));
      assign plan_nz[gi] = (plan_reg != '0);
      assign inv_vec[gi] = inv_reg;
    end
  endgenerate

  always_comb begin
    pick_any  = |fit_vec;
    pick_idx  = 2'd0;
    if (fit_vec[2])
      pick_idx = 2'd2;
    else if (fit_vec[1])
      pick_idx = 2'd1;

    plan_any = |plan_nz;
    coin_sel = 2'd0;
    if (plan_nz[2])
      coin_sel = 2'd2;
    else if (plan_nz[1])
      coin_sel = 2'd1;

    plan_take = (state_reg == PLAN) && (rem_reg != '0) && pick_any;
    plan_fail = (state_reg == PLAN) && (rem_reg != '0) && !pick_any;
    coin_hs   = (state_reg == CHANGE) && plan_any && bus.coin_ready;

    busy       = (state_reg != IDLE);
    item_valid = (state_reg == ITEM);
    coin_valid = (state_reg == CHANGE) && plan_any;
    coin_type  = coin_valid ? coin_sel : 2'd0;
    done       = (state_reg == FINISH);

    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.vend_req) state_next = CHECK;
      CHECK:   state_next = (credit_reg < price_reg) ? FINISH : PLAN;
      PLAN: begin
        if (rem_reg == '0)
          state_next = ITEM;
        else if (plan_fail)
          state_next = FINISH;
      end
      ITEM:    if (bus.item_ready) state_next = CHANGE;
      CHANGE:  if (!plan_any) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // status only changes on the edge that enters FINISH, so it moves together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
      price_reg  <= '0;
      rem_reg    <= '0;
      item_reg   <= '0;
      status_reg <= ST_OK;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (bus.vend_req) begin
            credit_reg <= bus.credit;
            price_reg  <= bus.price;
            item_reg   <= bus.vend_item;
          end
        end
        CHECK: begin
          if (credit_reg < price_reg)
            status_reg <= ST_CREDIT;
          else
            rem_reg <= credit_reg - price_reg;
        end
        PLAN: begin
          if (plan_take)
            rem_reg <= rem_reg - coin_value(pick_idx);
          else if (plan_fail)
            status_reg <= ST_CHANGE;
        end
        CHANGE: begin
          if (!plan_any)
            status_reg <= ST_OK;
        end
        default: ;
      endcase
    end
  end

`ifdef VEND_STATS_EN
  logic [15:0] sales_reg, cents_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sales_reg <= '0;
      cents_reg <= '0;
    end else begin
      if (state_reg == FINISH && status_reg == ST_OK)
        sales_reg <= sales_reg + 16'd1;
      if (coin_hs)
        cents_reg <= cents_reg + 16'(coin_value(coin_sel));
    end
  end

  assign bus.sales_cnt    = sales_reg;
  assign bus.change_cents = cents_reg;
`endif

  assign bus.busy       = busy;
  assign bus.item_valid = item_valid;
  assign bus.item_sel   = item_reg;
  assign bus.coin_valid = coin_valid;
  assign bus.coin_type  = coin_type;
  assign bus.done       = done;
  assign bus.status     = status_reg;
  assign bus.inv_n      = inv_vec[0];
  assign bus.inv_d      = inv_vec[1];
  assign bus.inv_q      = inv_vec[2];

endmodule

// File: doc/vend_change_controller.md
Name: vend_change_controller

Overview:
- Sequences one vend transaction for the vending machine datapath: validates credit against price, plans change from the on-hand coin inventory, releases the item, then issues change coins one at a time over a valid/ready handshake.
- Sits between the coin-acceptance/credit logic (upstream) and the item and coin-hopper actuators (downstream).
- Owns the nickel, dime and quarter inventory counters.

Parameters:
- CREDIT_W, 8, width of credit/price in cents (max 255)
- INV_W, 6, width of each coin inventory counter
- INIT_N, 20, nickel count loaded at reset
- INIT_D, 20, dime count loaded at reset
- INIT_Q, 20, quarter count loaded at reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- vend_req  in  1  start transaction; sampled only in IDLE
- vend_item  in  3  item select, latched with vend_req
- credit  in  CREDIT_W  inserted cents, latched with vend_req
- price  in  CREDIT_W  item price in cents, latched with vend_req
- busy  out  1  high in any state other than IDLE
- item_valid  out  1  item release request
- item_sel  out  3  latched vend_item, valid while item_valid
- item_ready  in  1  item actuator accepts
- coin_valid  out  1  change coin request
- coin_type  out  2  00 nickel, 01 dime, 10 quarter
- coin_ready  in  1  hopper accepts coin
- done  out  1  one-cycle pulse, transaction end
- status  out  2  00 ok, 01 insufficient credit, 10 cannot make change; valid with done, held until next done
- refill_valid  in  1  add one coin to inventory
- refill_type  in  2  coin type for refill
- inv_n, inv_d, inv_q  out  INV_W each  current inventory counts

Behaviour:
- Reset: state IDLE; busy, item_valid, coin_valid and done are 0; status, item_sel and coin_type are 0; inventories are loaded with INIT_N/INIT_D/INIT_Q; plan counters are 0.
- States: IDLE, CHECK, PLAN, ITEM, CHANGE, FINISH.
- IDLE: on vend_req, latch credit, price and vend_item; go to CHECK.
- CHECK (1 cycle):
  - credit < price: status=01, go to FINISH.
  - Otherwise rem = credit - price (CREDIT_W bits, no overflow possible); shadow inventories are copied from the live ones; go to PLAN.
- PLAN: one greedy step per cycle.
  - rem==0: go to ITEM.
  - Else the largest coin with value <= rem and shadow count > 0 is chosen, priority Q(25) > D(10) > N(5). Its shadow count is decremented, its plan count (pq/pd/pn) is incremented, and its value is subtracted from rem.
  - If no coin qualifies (including rem%5 != 0): status=10, clear plan counts, go to FINISH. Live inventory is untouched.
  - Worst case is 51 cycles.
- ITEM: item_valid=1 until item_valid&&item_ready, then go to CHANGE.
- CHANGE: coin_valid=1 while any plan count > 0.
  - coin_type selects the highest planned denomination (Q, then D, then N).
  - coin_type is stable while coin_valid is high and coin_ready is low.
  - On handshake, decrement that plan count and the live inventory for that coin.
  - When all plan counts are 0, status=00, go to FINISH. With zero change the block passes straight through with no coin cycles.
- FINISH: done=1 for one cycle, return to IDLE.
- Transaction latency is 2 cycles (IDLE→CHECK→FINISH, done one cycle after CHECK) for the reject paths; success is CHECK + PLAN steps + handshakes + FINISH.
- Refill is accepted only in IDLE. The counter saturates at 2^INV_W-1, refill_type 11 is ignored, and refill outside IDLE is dropped.
- If vend_req and refill_valid arrive together in IDLE, both take effect. CHECK copies the post-refill inventory.
- Reset asserted mid-transaction aborts immediately: no done, actuators are released, and inventory returns to INIT values.

Optional Feature:
- VEND_STATS_EN defined:
  - Adds outputs sales_cnt (16) and change_cents (16), both reset to 0.
  - sales_cnt increments on each done with status 00.
  - change_cents adds the coin value on each coin handshake.
  - Both wrap at 2^16.
- Not defined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- price=150, credit=150, item_ready=1 → one item handshake, no coin_valid, done with status=00, inventories unchanged.
- price=150, credit=190 → item handshake, then coins Q, D, N in that order; done status=00; inv_q=19, inv_d=19, inv_n=19.
- price=150, credit=100 → done 2 cycles after vend_req with status=01; item_valid and coin_valid never asserted.
- inv_q=0 (reset with INIT_Q=0), change 30 → coins D, D, D; inv_d=17.
- INIT_N=0, INIT_D=0, change 5 → status=10, no item or coins, inventories unchanged; separately, credit=153 with price=150 → status=10.
- coin_ready held low 3 cycles mid-CHANGE → coin_valid and coin_type held stable, no decrement. Then assert rst_n=0 mid-CHANGE → outputs return to reset values at once and inventories reload to INIT.
